// File: rtl/mm_sched_pkg.sv
// Shared types and constants for the blocked matrix-multiply job scheduler.
// Holds the FSM state enum, the dimension typedef and the N1/N2 log2 constants.
package mm_sched_pkg;

    localparam int N1_DEF           = 4;
    localparam int N2_DEF           = 4;
    localparam int MATRIXSIZE_W_DEF = 24;
    localparam int LOG2_N1          = $clog2(N1_DEF);
    localparam int LOG2_N2          = $clog2(N2_DEF);

    typedef logic [MATRIXSIZE_W_DEF-1:0] dim_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV,
        S_CHECK,
        S_WAIT_LD,
        S_RUN,
        S_GAP,
        S_DRAIN
    } state_t;

    // States in which a drain completion belongs to the running job.
    function automatic logic in_job(state_t s);
        return (s == S_WAIT_LD) || (s == S_RUN) ||
               (s == S_GAP) || (s == S_DRAIN);
    endfunction

endpackage

// File: rtl/mm_cfg_div.sv
// Iterative subtract divider: one subtraction per cycle after start.
// Ports: start/dividend/divisor in; quotient/remainder/done out.
module mm_cfg_div #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         done
);

    logic         busy_q;
    logic [W-1:0] div_q;
    logic [W-1:0] rem_q;
    logic [W-1:0] quo_q;
    logic         step;

    // A zero divisor never steps, so the divide ends in one cycle and
    // the zero field is rejected afterwards.
    assign step      = busy_q && (div_q != '0) && (rem_q >= div_q);
    assign done      = busy_q && !step;
    assign quotient  = quo_q;
    assign remainder = rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            div_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            div_q  <= divisor;
            rem_q  <= dividend;
            quo_q  <= '0;
        end else if (step) begin
            rem_q  <= rem_q - div_q;
            quo_q  <= quo_q + W'(1);
        end else if (done) begin
            busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/mm_block_sched.sv
// Job scheduler: validates a multiply descriptor, derives the datapath
// dimensions, then steps load/run/gap per column block and waits for drain.
// Ports: cfg_* handshake in, abort/blk_loaded/done_* in;
// start_multiply(_block), blk_idx, derived dims, job_done, cfg_err out.
module mm_block_sched
    import mm_sched_pkg::*;
#(
    parameter int N1           = N1_DEF,
    parameter int N2           = N2_DEF,
    parameter int MATRIXSIZE_W = MATRIXSIZE_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [MATRIXSIZE_W-1:0] cfg_M1,
    input  logic [MATRIXSIZE_W-1:0] cfg_M2,
    input  logic [MATRIXSIZE_W-1:0] cfg_M3,
    input  logic [MATRIXSIZE_W-1:0] cfg_BLOCK_WIDTH,
    input  logic                    abort,
    input  logic                    blk_loaded,
    input  logic                    done_read_control,
    input  logic                    done_multiply,
    output logic                    start_multiply,
    output logic                    start_multiply_block,
    output logic [MATRIXSIZE_W-1:0] blk_idx,
    output logic [MATRIXSIZE_W-1:0] BLOCKS,
    output logic [MATRIXSIZE_W-1:0] BLOCK_WIDTHdN2,
    output logic [MATRIXSIZE_W-1:0] BLOCK_SIZEdN2,
    output logic [MATRIXSIZE_W-1:0] M1xBLOCK_WIDTHdN1xN2,
    output logic [MATRIXSIZE_W-1:0] M1xBLOCK_WIDTHdN1,
    output logic [MATRIXSIZE_W-1:0] M1xM3dN1,
    output logic [MATRIXSIZE_W-1:0] M1dN1,
    output logic [MATRIXSIZE_W-1:0] M3dN2,
    output logic                    job_done,
    output logic                    cfg_err
);

    localparam int L1 = $clog2(N1);
    localparam int L2 = $clog2(N2);

    typedef logic [MATRIXSIZE_W-1:0] fld_t;

    localparam fld_t ONE    = MATRIXSIZE_W'(1);
    localparam fld_t N1_MSK = MATRIXSIZE_W'(N1 - 1);
    localparam fld_t N2_MSK = MATRIXSIZE_W'(N2 - 1);

    state_t state_q;
    state_t state_n;

    fld_t m1_q;
    fld_t m2_q;
    fld_t m3_q;
    fld_t bw_q;
    fld_t div_quo;
    fld_t div_rem;
    fld_t m2xbw;
    fld_t m1xbw;
    fld_t m1xm3;

    logic accept;
    logic div_done;
    logic cfg_ok;
    logic last_blk;
    logic drain_q;
    logic load_cfg;
    logic smb_n;
    logic sm_n;
    logic done_n;
    logic err_n;

    mm_cfg_div #(
        .W(MATRIXSIZE_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (accept),
        .dividend (cfg_M3),
        .divisor  (cfg_BLOCK_WIDTH),
        .quotient (div_quo),
        .remainder(div_rem),
        .done     (div_done)
    );

    assign accept = cfg_valid && cfg_ready;

    // Products wrap at the field width before the power-of-two divide.
    assign m2xbw = m2_q * bw_q;
    assign m1xbw = m1_q * bw_q;
    assign m1xm3 = m1_q * m3_q;

    assign cfg_ok = (m1_q != '0) && (m2_q != '0) &&
                    (m3_q != '0) && (bw_q != '0) &&
                    ((m1_q & N1_MSK) == '0) &&
                    ((m3_q & N2_MSK) == '0) &&
                    ((bw_q & N2_MSK) == '0) &&
                    (div_rem == '0);

    assign last_blk = (blk_idx + ONE) >= BLOCKS;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        if (abort && (state_q != S_IDLE)) begin
            state_n = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:    if (cfg_valid) state_n = S_DIV;
                S_DIV:     if (div_done) state_n = S_CHECK;
                S_CHECK:   state_n = cfg_ok ? S_WAIT_LD : S_IDLE;
                S_WAIT_LD: if (blk_loaded) state_n = S_RUN;
                S_RUN: begin
                    if (done_read_control)
                        state_n = last_blk ? S_DRAIN : S_GAP;
                end
                S_GAP:     state_n = S_WAIT_LD;
                S_DRAIN:   if (drain_q) state_n = S_IDLE;
                default:   state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_ready = (state_q == S_IDLE);
        load_cfg  = (state_q == S_CHECK) && (state_n == S_WAIT_LD);
        smb_n     = (state_n == S_GAP);
        done_n    = (state_q == S_DRAIN) && drain_q && !abort;
        err_n     = (state_q == S_CHECK) && !cfg_ok && !abort;
        sm_n      = start_multiply;
        if (state_n == S_IDLE) begin
            sm_n = 1'b0;
        end else if (state_n == S_RUN) begin
            sm_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_multiply       <= 1'b0;
            start_multiply_block <= 1'b0;
            job_done             <= 1'b0;
            cfg_err              <= 1'b0;
            blk_idx              <= '0;
            drain_q              <= 1'b0;
            m1_q                 <= '0;
            m2_q                 <= '0;
            m3_q                 <= '0;
            bw_q                 <= '0;
        end else begin
            start_multiply       <= sm_n;
            start_multiply_block <= smb_n;
            job_done             <= done_n;
            cfg_err              <= err_n;
            if (accept) begin
                blk_idx <= '0;
                m1_q    <= cfg_M1;
                m2_q    <= cfg_M2;
                m3_q    <= cfg_M3;
                bw_q    <= cfg_BLOCK_WIDTH;
            end else if (smb_n) begin
                blk_idx <= blk_idx + ONE;
            end
            // Sticky so a drain that finishes before the last block is
            // issued still releases DRAIN later.
            if (accept) begin
                drain_q <= 1'b0;
            end else if (in_job(state_q) && done_multiply) begin
                drain_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            BLOCKS               <= '0;
            BLOCK_WIDTHdN2       <= '0;
            BLOCK_SIZEdN2        <= '0;
            M1xBLOCK_WIDTHdN1xN2 <= '0;
            M1xBLOCK_WIDTHdN1    <= '0;
            M1xM3dN1             <= '0;
            M1dN1                <= '0;
            M3dN2                <= '0;
        end else if (load_cfg) begin
            BLOCKS               <= div_quo;
            BLOCK_WIDTHdN2       <= bw_q >> L2;
            BLOCK_SIZEdN2        <= m2xbw >> L2;
            M1xBLOCK_WIDTHdN1xN2 <= m1xbw >> (L1 + L2);
            M1xBLOCK_WIDTHdN1    <= m1xbw >> L1;
            M1xM3dN1             <= m1xm3 >> L1;
            M1dN1                <= m1_q >> L1;
            M3dN2                <= m3_q >> L2;
        end
    end

endmodule

// File: doc/mm_block_sched.md
# mm_block_sched

Job-level scheduler for the blocked matrix-multiply datapath: sequences the s2mm loader, read controller, systolic array and D drain through all column blocks of one multiply. Accepts a job descriptor over a valid/ready handshake, then validates it and computes every derived dimension the datapath consumes. Holds `start_multiply` high for the job and pulses `start_multiply_block` between blocks. Reports job completion or a configuration error.

## Interface
Parameters:
- `N1`, 4: systolic rows; power of two.
- `N2`, 4: systolic columns; power of two.
- `MATRIXSIZE_W`, 24: width of every dimension field.

Ports:
- `clk`  in  1  single clock (fast datapath clock).
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  job descriptor valid.
- `cfg_ready`  out  1  high only in IDLE.
- `cfg_M1`, `cfg_M2`, `cfg_M3`, `cfg_BLOCK_WIDTH`  in  MATRIXSIZE_W each  job dimensions.
- `abort`  in  1  synchronous job cancel.
- `blk_loaded`  in  1  level; next B block resident in ping-pong buffer.
- `done_read_control`  in  1  current block fully issued to array.
- `done_multiply`  in  1  D drain complete; pulse or level.
- `start_multiply`  out  1  held high from first block start to job end.
- `start_multiply_block`  out  1  one-cycle pulse between blocks.
- `blk_idx`  out  MATRIXSIZE_W  current block index.
- `BLOCKS`, `BLOCK_WIDTHdN2`, `BLOCK_SIZEdN2`, `M1xBLOCK_WIDTHdN1xN2`, `M1xBLOCK_WIDTHdN1`, `M1xM3dN1`, `M1dN1`, `M3dN2`  out  MATRIXSIZE_W each  derived configuration.
- `job_done`  out  1  one-cycle pulse.
- `cfg_err`  out  1  one-cycle pulse; descriptor rejected.

## Operation
- FSM states and transitions:
  - IDLE: accept on `cfg_valid & cfg_ready`; latch fields; go to DIV.
  - DIV: iterative divide. Remainder starts at M3; each cycle subtract BW and increment BLOCKS while remainder ≥ BW; then go to CHECK.
  - CHECK: reject if any of M1%N1, M3%N2, BW%N2, or the final remainder is nonzero, or if any field is zero. Otherwise register all derived values.
  - WAIT_LD: wait for `blk_loaded`.
  - RUN: `start_multiply`=1; wait for `done_read_control`.
  - GAP: one cycle; pulse `start_multiply_block`; increment `blk_idx`.
  - DRAIN: wait for the sticky drain flag.
  - Rejection path: CHECK→IDLE with `cfg_err`.
  - Success path: CHECK→WAIT_LD→RUN. In RUN, if `blk_idx`<BLOCKS-1 go GAP→WAIT_LD; otherwise go DRAIN. DRAIN→IDLE with `job_done`.
- Derived values; divisions by N1/N2 are right shifts, products are truncated to MATRIXSIZE_W:
  - `BLOCK_WIDTHdN2`=BW/N2
  - `BLOCK_SIZEdN2`=M2·BW/N2
  - `M1xBLOCK_WIDTHdN1`=M1·BW/N1
  - `M1xBLOCK_WIDTHdN1xN2`=M1·BW/(N1·N2)
  - `M1xM3dN1`=M1·M3/N1
  - `M1dN1`=M1/N1
  - `M3dN2`=M3/N2
- Drain flag: set by `done_multiply` in any of RUN, GAP, WAIT_LD or DRAIN; cleared on accept. An early drain is therefore never lost.
- `abort` (priority below `rst`): from any non-IDLE state go IDLE next cycle. Drop `start_multiply`; no `job_done`, no `cfg_err`. Derived outputs keep their values.
- Derived outputs stay stable from CHECK until the next accept.

## Timing
- Reset values: state IDLE, `cfg_ready`=1, all other outputs 0.
- `cfg_ready` is combinational from state; it is never high outside IDLE.
- DIV latency is BLOCKS+1 cycles, bounded at M3/BW+1.
- `start_multiply` rises in the first RUN cycle, registered. It stays high through GAP and WAIT_LD and falls on the cycle `job_done` pulses.
- The `start_multiply_block` pulse occurs in exactly one cycle per block boundary, BLOCKS-1 pulses per job. `blk_idx` updates in the same cycle.
- `done_read_control` and `blk_loaded` asserted in the same cycle: RUN→GAP is taken, and `blk_loaded` is re-sampled in WAIT_LD on the following cycle.
- `done_read_control` outside RUN is ignored.

## Structure
- Package `mm_sched_pkg`: state enum, field-width typedef from MATRIXSIZE_W, `LOG2_N1`/`LOG2_N2` constants.
- Sub-module `mm_cfg_div`: the iterative subtract divider (start, dividend, divisor → quotient, remainder, done).

## Test plan
- Job M1=8, M2=16, M3=16, BW=8 → BLOCKS=2, BLOCK_WIDTHdN2=2, BLOCK_SIZEdN2=32, M1xBLOCK_WIDTHdN1xN2=4, M1xBLOCK_WIDTHdN1=16, M1xM3dN1=32, M1dN1=2, M3dN2=4. Expect one `start_multiply_block` pulse and one `job_done`.
- M3=20, BW=8 → `cfg_err` 1 pulse after DIV+CHECK; `start_multiply` never rises; `cfg_ready`=1 next cycle.
- `done_multiply` pulsed during the last RUN, before `done_read_control` → `job_done` one cycle after DRAIN entry, no hang.
- `blk_loaded` held low 10 cycles in WAIT_LD → `start_multiply` stays 1, `blk_idx` is unchanged, and no pulse occurs until `blk_loaded` rises.
- `abort` in RUN of block 1 of 4 → IDLE next cycle; `start_multiply`=0; no `job_done`. A new job is then accepted and `blk_idx` restarts at 0.
- `rst` asserted mid-DIV → all outputs 0, `cfg_ready`=1 the following cycle.
